// File: rtl/pattern_serializer_pkg.sv
// Shared definitions for the pattern serializer and the 1011 detector benches:
// FSM state encodings, default sizing and the reference pattern.
package pattern_serializer_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_LEN_W = 4;
   localparam int DEF_REP_W = 4;

   localparam logic [3:0] PAT_1011 = 4'b1011;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

endpackage

// File: rtl/pattern_serializer.sv
// Parallel-load, MSB-first serializer that repeats a pattern load_rep+1 times
// back to back, then pulses done in the first idle cycle.
module pattern_serializer
   import pattern_serializer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LEN_W = DEF_LEN_W,
   parameter int REP_W = DEF_REP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic [LEN_W-1:0] load_len,
   input  logic [REP_W-1:0] load_rep,
   input  logic             abort,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             done
);

   localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [LEN_W-1:0] last_idx_q, last_idx_d;
   logic [LEN_W-1:0] bit_idx_q, bit_idx_d;
   logic [REP_W-1:0] pass_cnt_q, pass_cnt_d;
   logic             dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [LEN_W-1:0] eff_len;

   function automatic logic bit_at(input logic [WIDTH-1:0] w, input logic [LEN_W-1:0] idx);
      return |(w & (WIDTH'(1) << idx));
   endfunction

   // Zero or oversize lengths fall back to the full word.
   always_comb begin
      eff_len = load_len;
      if ((load_len == '0) || (load_len > WIDTH_L)) begin
         eff_len = WIDTH_L;
      end
   end

   assign load_ready = (state_q == ST_IDLE) && !rst;

   always_comb begin
      state_d      = state_q;
      data_d       = data_q;
      last_idx_d   = last_idx_q;
      bit_idx_d    = bit_idx_q;
      pass_cnt_d   = pass_cnt_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      busy_d       = busy_q;
      done_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (load_valid && load_ready) begin
               data_d       = load_data;
               last_idx_d   = eff_len - LEN_W'(1);
               bit_idx_d    = eff_len - LEN_W'(1);
               pass_cnt_d   = load_rep;
               dout_d       = bit_at(load_data, eff_len - LEN_W'(1));
               dout_valid_d = 1'b1;
               busy_d       = 1'b1;
               state_d      = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               state_d      = ST_IDLE;
               dout_d       = 1'b0;
               dout_valid_d = 1'b0;
               busy_d       = 1'b0;
            end else if (bit_idx_q != '0) begin
               bit_idx_d = bit_idx_q - LEN_W'(1);
               dout_d    = bit_at(data_q, bit_idx_q - LEN_W'(1));
            end else if (pass_cnt_q != '0) begin
               // Wrap straight into the next pass so the bit stream stays gap-free.
               pass_cnt_d = pass_cnt_q - REP_W'(1);
               bit_idx_d  = last_idx_q;
               dout_d     = bit_at(data_q, last_idx_q);
            end else begin
               state_d      = ST_IDLE;
               dout_d       = 1'b0;
               dout_valid_d = 1'b0;
               busy_d       = 1'b0;
               done_d       = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         data_q       <= '0;
         last_idx_q   <= '0;
         bit_idx_q    <= '0;
         pass_cnt_q   <= '0;
         dout_q       <= 1'b0;
         dout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         data_q       <= data_d;
         last_idx_q   <= last_idx_d;
         bit_idx_q    <= bit_idx_d;
         pass_cnt_q   <= pass_cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer with a behavioural 1011 detector on dout.
module tb_pattern_serializer;
   import pattern_serializer_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_valid;
   logic       load_ready;
   logic [7:0] load_data;
   logic [3:0] load_len;
   logic [3:0] load_rep;
   logic       abort;
   logic       dout;
   logic       dout_valid;
   logic       busy;
   logic       done;

   int n_pass  = 0;
   int n_total = 0;
   int det_hits;

   logic [31:0] got;
   int          nbits, nbusy, ndone_mid;
   logic        end_done, end_dout, end_busy;
   bit          timeout;

   pattern_serializer dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .load_len(load_len), .load_rep(load_rep),
      .abort(abort), .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a load request and let the accepting edge pass, then scramble the source.
   task automatic do_load(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
      load_valid = 1'b1;
      load_data  = d;
      load_len   = l;
      load_rep   = r;
      tick();
      load_valid = 1'b0;
      load_data  = ~d;
      load_len   = 4'd1;
      load_rep   = 4'd7;
   endtask

   // Gather the bit stream of the frame in flight until dout_valid drops.
   task automatic collect();
      logic [3:0] hist;
      hist      = 4'b0000;
      got       = '0;
      nbits     = 0;
      nbusy     = 0;
      ndone_mid = 0;
      det_hits  = 0;
      end_done  = 1'b0;
      end_dout  = 1'b1;
      end_busy  = 1'b1;
      timeout   = 1'b1;
      for (int c = 0; c < 100; c++) begin
         if (!dout_valid) begin
            end_done = done;
            end_dout = dout;
            end_busy = busy;
            timeout  = 1'b0;
            break;
         end
         got  = {got[30:0], dout};
         hist = {hist[2:0], dout};
         if (hist == PAT_1011) det_hits++;
         nbits++;
         if (busy) nbusy++;
         if (done) ndone_mid++;
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; load_valid = 1'b1; load_data = 8'hFF; load_len = 4'd4; load_rep = 4'd0; abort = 1'b0;
      tick();
      tick();
      tick();
      n_total++; if ({dout, dout_valid, busy, done} !== 4'b0000) $display("FAIL reset_outputs: got %b expected 0000", {dout, dout_valid, busy, done}); else n_pass++;
      n_total++; if (load_ready !== 1'b0) $display("FAIL reset_ready_low: got %b expected 0", load_ready); else n_pass++;
      rst = 1'b0; load_valid = 1'b0;
      #1;
      n_total++; if (load_ready !== 1'b1) $display("FAIL reset_ready_high: got %b expected 1", load_ready); else n_pass++;
      tick();
      n_total++; if ({dout_valid, busy} !== 2'b00) $display("FAIL reset_no_accept: got %b expected 00", {dout_valid, busy}); else n_pass++;
   endtask

   task automatic test_single();
      do_load(8'h0B, 4'd4, 4'd0);
      collect();
      n_total++; if (timeout !== 1'b0) $display("FAIL single_timeout: got %b expected 0", timeout); else n_pass++;
      n_total++; if (nbits !== 4) $display("FAIL single_nbits: got %0d expected 4", nbits); else n_pass++;
      n_total++; if (got !== 32'hB) $display("FAIL single_bits: got %h expected 0000000b", got); else n_pass++;
      n_total++; if (det_hits !== 1) $display("FAIL single_detect: got %0d expected 1", det_hits); else n_pass++;
      n_total++; if ({end_done, end_dout, end_busy, ndone_mid == 0} !== 4'b1001) $display("FAIL single_done: got %b expected 1001", {end_done, end_dout, end_busy, ndone_mid == 0}); else n_pass++;
      tick();
      n_total++; if (done !== 1'b0) $display("FAIL single_done_pulse: got %b expected 0", done); else n_pass++;
   endtask

   task automatic test_repeat();
      do_load(8'h0B, 4'd4, 4'd2);
      collect();
      n_total++; if (nbits !== 12) $display("FAIL repeat_nbits: got %0d expected 12", nbits); else n_pass++;
      n_total++; if (got !== 32'hBBB) $display("FAIL repeat_bits: got %h expected 00000bbb", got); else n_pass++;
      n_total++; if (nbusy !== 12) $display("FAIL repeat_busy: got %0d expected 12", nbusy); else n_pass++;
      n_total++; if (det_hits !== 3) $display("FAIL repeat_detect: got %0d expected 3", det_hits); else n_pass++;
      n_total++; if ({end_done, end_busy, ndone_mid == 0} !== 3'b101) $display("FAIL repeat_done: got %b expected 101", {end_done, end_busy, ndone_mid == 0}); else n_pass++;
      tick();
   endtask

   task automatic test_len_clamp();
      do_load(8'hA5, 4'd0, 4'd0);
      collect();
      n_total++; if ({nbits[7:0], got[7:0]} !== {8'd8, 8'hA5}) $display("FAIL len0_bits: got %0d/%h expected 8/a5", nbits, got); else n_pass++;
      tick();
      do_load(8'h3C, 4'd9, 4'd0);
      collect();
      n_total++; if ({nbits[7:0], got[7:0]} !== {8'd8, 8'h3C}) $display("FAIL len9_bits: got %0d/%h expected 8/3c", nbits, got); else n_pass++;
      tick();
      do_load(8'hF5, 4'd3, 4'd1);
      collect();
      n_total++; if ({nbits[7:0], got[7:0]} !== {8'd6, 8'h2D}) $display("FAIL len3_bits: got %0d/%h expected 6/2d", nbits, got); else n_pass++;
      tick();
   endtask

   task automatic test_abort();
      do_load(8'hA5, 4'd8, 4'd0);
      tick();
      tick();
      n_total++; if ({dout_valid, dout} !== 2'b11) $display("FAIL abort_third_bit: got %b expected 11", {dout_valid, dout}); else n_pass++;
      // Abort stays high into IDLE together with the reload request.
      abort = 1'b1; load_valid = 1'b1; load_data = 8'h0B; load_len = 4'd4; load_rep = 4'd0;
      tick();
      n_total++; if ({dout_valid, dout, busy, done, load_ready} !== 5'b00001) $display("FAIL abort_idle: got %b expected 00001", {dout_valid, dout, busy, done, load_ready}); else n_pass++;
      tick();
      abort = 1'b0; load_valid = 1'b0; load_data = 8'hF4;
      collect();
      n_total++; if ({nbits[7:0], got[7:0], end_done} !== {8'd4, 8'h0B, 1'b1}) $display("FAIL abort_reload: got %0d/%h/%b expected 4/0b/1", nbits, got, end_done); else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [3:0] bits_a;
      int         ready_hi;
      bits_a   = '0;
      ready_hi = 0;
      load_valid = 1'b1; load_data = 8'h0B; load_len = 4'd4; load_rep = 4'd0;
      tick();
      load_data = 8'h06;
      for (int i = 0; i < 4; i++) begin
         bits_a = {bits_a[2:0], dout & dout_valid};
         if (load_ready) ready_hi++;
         tick();
      end
      n_total++; if (bits_a !== 4'b1011) $display("FAIL b2b_first: got %b expected 1011", bits_a); else n_pass++;
      n_total++; if (ready_hi !== 0) $display("FAIL b2b_ready_mid: got %0d expected 0", ready_hi); else n_pass++;
      n_total++; if ({dout_valid, done, load_ready} !== 3'b011) $display("FAIL b2b_gap: got %b expected 011", {dout_valid, done, load_ready}); else n_pass++;
      tick();
      load_valid = 1'b0; load_data = 8'hFF;
      collect();
      n_total++; if ({nbits[7:0], got[7:0]} !== {8'd4, 8'h06}) $display("FAIL b2b_second: got %0d/%h expected 4/06", nbits, got); else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid();
      do_load(8'hA5, 4'd8, 4'd3);
      tick();
      rst = 1'b1;
      tick();
      n_total++; if ({dout_valid, dout, busy, done, load_ready} !== 5'b00000) $display("FAIL rstmid_outputs: got %b expected 00000", {dout_valid, dout, busy, done, load_ready}); else n_pass++;
      rst = 1'b0;
      tick();
      n_total++; if ({dout_valid, busy, done, load_ready} !== 4'b0001) $display("FAIL rstmid_after: got %b expected 0001", {dout_valid, busy, done, load_ready}); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_repeat();
      test_len_clamp();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
- Transmit-side counterpart of the serial 1011 pattern detector.
- Accepts a parallel pattern word through a valid/ready load handshake and shifts it out MSB-first, one bit per clock.
- Emits the pattern a programmable number of times, then returns to idle.
- Its serial output drives the detector's din input in benches and in loopback builds.

Parameters:
- WIDTH, 8, maximum pattern length in bits.
- LEN_W, 4, width of the length field; must satisfy 2^LEN_W > WIDTH.
- REP_W, 4, width of the repeat-count field.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- load_valid  in  1  pattern load request.
- load_ready  out  1  block can accept a load.
- load_data  in  WIDTH  pattern; bits [len-1:0] are used.
- load_len  in  LEN_W  pattern length in bits.
- load_rep  in  REP_W  extra passes; total passes = load_rep+1.
- abort  in  1  cancel current transmission.
- dout  out  1  serial data.
- dout_valid  out  1  dout carries a pattern bit.
- busy  out  1  transmission in progress.
- done  out  1  one-cycle pulse after the last bit of the last pass.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); it is sampled only on the rising edge of clk.
- Reset values: dout=0, dout_valid=0, busy=0, done=0, state=IDLE, load_ready=1 from the cycle after reset is released.
- States: IDLE, SHIFT.
- load_ready = (state==IDLE) && !rst. It is combinational from state; all other outputs are registered.
- Accept: load_valid && load_ready at a clk edge.
  - Capture data and rep; capture len after the clamp rule below.
  - Same edge: dout <= data[len-1], dout_valid <= 1, busy <= 1, bit_idx <= len-1, pass_cnt <= rep, state <= SHIFT.
  - Latency: the first bit is visible in the cycle immediately after the accepting edge.
- Length clamp: load_len==0 or load_len>WIDTH is treated as WIDTH.
- SHIFT, each edge with no abort:
  - bit_idx>0: bit_idx--, dout <= data[bit_idx-1].
  - bit_idx==0 and pass_cnt>0: pass_cnt--, bit_idx <= len-1, dout <= data[len-1]. There is no gap between passes; dout_valid stays 1.
  - bit_idx==0 and pass_cnt==0: state <= IDLE, dout <= 0, dout_valid <= 0, busy <= 0, done <= 1.
- done is high for exactly one cycle, the first cycle with dout_valid=0.
  - load_ready is already 1 in that cycle, so the next frame can be accepted at the edge that ends it.
  - The minimum inter-frame gap is therefore 1 idle cycle.
- Total dout_valid cycles per frame = len*(rep+1), always contiguous.
- Idle line level is dout=0. dout is 0 whenever dout_valid=0.
- abort:
  - In SHIFT: next edge forces IDLE, dout=0, dout_valid=0, busy=0. done is not asserted.
  - In IDLE: ignored, and it does not block a simultaneous accept.
- load_valid during SHIFT: ignored; load_ready=0, and the source must hold its request.
- rst during SHIFT: immediate return to reset values at that edge; no done; the captured pattern is discarded.
- rst and load_valid in the same cycle: reset wins; nothing is accepted.
- Changing load_data after the accepting edge has no effect on the current frame.

Decomposition:
- Shared header pattern_defs.vh holds:
  - state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - default WIDTH/LEN_W/REP_W;
  - localparam PAT_1011 = 4'b1011, which the detector and its benches share.
- No sub-module is needed; the shift/count datapath and the two-state FSM form one module.
- Benches instantiate pattern_serializer driving the detector's din for loopback checks.

Test Plan:
- Reset, then hold rst high for 2 cycles while load_valid=1 -> no accept; dout=0, dout_valid=0, busy=0, load_ready=0 during reset and 1 after.
- Load data=8'h0B, len=4, rep=0 -> dout 1,0,1,1 on 4 consecutive cycles with dout_valid=1; done pulse on cycle 5; the detector fires once on the final 1.
- Load data=8'h0B, len=4, rep=2 -> 12 contiguous bits 1011 1011 1011; busy high for 12 cycles; single done pulse; no gaps between passes.
- len=0 with data=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1. Separately, len=9 clamps to 8 bits.
- Assert abort on the 3rd bit of an 8-bit frame -> dout_valid drops after that edge, no done; an immediate reload is accepted the next cycle.
- Hold load_valid high continuously with two queued frames (len=4 each) -> second accept occurs on the done cycle; exactly 1 idle cycle between frames; a load_valid presented mid-frame is not accepted.
